// File: rtl/div_unit.sv
// Multicycle radix-2 restoring divider (signed/unsigned) for the MIPS32 Execute stage.
// Optional macro DIV_EARLY_TERM_EN: finish in one cycle when |Divisor| > |Dividend|.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             OP_div,
    input  logic             OP_divu,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall,
    output logic             DivZero
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] raw_dvd;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             zero_dvs;
    logic             early;

    logic             start_c;
    logic             sgn_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic             early_c;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH:0]   diff_c;
    logic             take_c;
    logic [WIDTH-1:0] rem_nx_c;
    logic [WIDTH-1:0] dvd_nx_c;
    logic [WIDTH-1:0] q_out_c;
    logic [WIDTH-1:0] r_out_c;

    // Start decode and operand magnitudes; OP_div wins when both are high.
    always_comb begin
        start_c = OP_div | OP_divu;
        sgn_c   = OP_div;
        mag_a_c = (sgn_c && Dividend[WIDTH-1]) ? WIDTH'(-Dividend) : Dividend;
        mag_b_c = (sgn_c && Divisor[WIDTH-1])  ? WIDTH'(-Divisor)  : Divisor;
`ifdef DIV_EARLY_TERM_EN
        early_c = (Divisor != '0) && (mag_b_c > mag_a_c);
`else
        early_c = 1'b0;
`endif
    end

    // One restoring step. The partial remainder is always below the divisor between
    // steps, so its 33rd bit is only needed in the shifted/trial value.
    always_comb begin
        rem_sh_c = {rem, dvd[WIDTH-1]};
        diff_c   = rem_sh_c - {1'b0, dvs};
        take_c   = ~diff_c[WIDTH];
        rem_nx_c = take_c ? diff_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
        dvd_nx_c = {dvd[WIDTH-2:0], take_c};
        q_out_c  = neg_q ? WIDTH'(-dvd_nx_c) : dvd_nx_c;
        r_out_c  = neg_r ? WIDTH'(-rem_nx_c) : rem_nx_c;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            raw_dvd   <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_dvs  <= 1'b0;
            early     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Stall     <= 1'b0;
            DivZero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state    <= BUSY;
                        Stall    <= 1'b1;
                        neg_q    <= sgn_c & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                        neg_r    <= sgn_c & Dividend[WIDTH-1];
                        dvd      <= mag_a_c;
                        dvs      <= mag_b_c;
                        raw_dvd  <= Dividend;
                        rem      <= '0;
                        cnt      <= CNT_W'(WIDTH);
                        zero_dvs <= (Divisor == '0);
                        early    <= early_c;
                    end
                end
                BUSY: begin
                    rem <= rem_nx_c;
                    dvd <= dvd_nx_c;
                    cnt <= cnt - CNT_W'(1);
                    if (early) begin
                        state     <= IDLE;
                        Stall     <= 1'b0;
                        Quotient  <= '0;
                        Remainder <= raw_dvd;
                        DivZero   <= 1'b0;
                    end else if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        Stall <= 1'b0;
                        if (zero_dvs) begin
                            Quotient  <= '1;
                            Remainder <= raw_dvd;
                            DivZero   <= 1'b1;
                        end else begin
                            Quotient  <= q_out_c;
                            Remainder <= r_out_c;
                            DivZero   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at start, checked on completion.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        OP_div = 1'b0;
    logic        OP_divu = 1'b0;
    logic [31:0] Dividend = '0;
    logic [31:0] Divisor = '0;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Stall;
    logic        DivZero;

    div_unit dut (
        .clock     (clock),
        .reset     (reset),
        .OP_div    (OP_div),
        .OP_divu   (OP_divu),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Stall     (Stall),
        .DivZero   (DivZero)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_q = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_cycles(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_TERM_EN
        return (b != 0 && mb > ma) ? 1 : 32;
`else
        return (b != 0 && mb > ma) ? 32 : 32;
`endif
    endfunction

    // Start one divide, wait for completion (bounded), compare against the queue head.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                          input logic dz, input int inject);
        exp_t e;
        int   cycles;
        e.tag = tag; e.q = q; e.r = r; e.dz = dz; e.cyc = exp_cycles(sgn, a, b);
        sb.push_back(e);
        @(negedge clock);
        OP_div = sgn; OP_divu = ~sgn; Dividend = a; Divisor = b;
        @(negedge clock);
        OP_div = 1'b0; OP_divu = 1'b0; Dividend = $urandom; Divisor = $urandom;
        cycles = 0;
        while (Stall && cycles < 100) begin
            if (cycles == 0) check($sformatf("%s.hold_q", tag), Quotient, last_q);
            cycles++;
            if (cycles == inject) begin
                OP_div = 1'b1; Dividend = 32'd50; Divisor = 32'd5;
            end else begin
                OP_div = 1'b0;
            end
            @(negedge clock);
        end
        OP_div = 1'b0;
        e = sb.pop_front();
        check($sformatf("%s.cycles", e.tag), 32'(cycles), 32'(e.cyc));
        check($sformatf("%s.q", e.tag), Quotient, e.q);
        check($sformatf("%s.r", e.tag), Remainder, e.r);
        check($sformatf("%s.dz", e.tag), 32'(DivZero), 32'(e.dz));
        last_q = e.q;
    endtask

    initial begin
        logic        [31:0] a;
        logic        [31:0] b;
        logic signed [31:0] sq;
        logic signed [31:0] sr;

        #1;
        check("rst.stall", 32'(Stall), 32'd0);
        check("rst.q", Quotient, 32'd0);
        check("rst.r", Remainder, 32'd0);
        check("rst.dz", 32'(DivZero), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, -1);
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, -1);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, -1);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, -1);
        do_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, -1);
        do_div("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, -1);
        do_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, -1);
        do_div("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, -1);
        do_div("u3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, -1);
        do_div("s_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1'b0, -1);
        do_div("u0_5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, -1);
        do_div("ign_start", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 10);

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 100000));
            do_div($sformatf("rnd_u%0d", i), 1'b0, a, b, a / b, a % b, 1'b0, -1);
            b = 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) b = -b;
            if (a == 32'h8000_0000) a = 32'd1;
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            do_div($sformatf("rnd_s%0d", i), 1'b1, a, b, sq, sr, 1'b0, -1);
        end

        // Asynchronous reset in the middle of a divide.
        @(negedge clock);
        OP_divu = 1'b1; Dividend = 32'd1000; Divisor = 32'd10;
        @(negedge clock);
        OP_divu = 1'b0;
        repeat (4) @(negedge clock);
        check("mid.stall_busy", 32'(Stall), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid.stall", 32'(Stall), 32'd0);
        check("mid.q", Quotient, 32'd0);
        check("mid.r", Remainder, 32'd0);
        check("mid.dz", 32'(DivZero), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid.stall_after", 32'(Stall), 32'd0);
        last_q = '0;
        do_div("post_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
